// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store data memory: funct3 and FSM
// encodings, byte-lane masks, store replication and load extraction.
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_D  = 3'b011,
        F3_BU = 3'b100,
        F3_HU = 3'b101,
        F3_WU = 3'b110
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    // Helpers work on the widest supported word; callers truncate to DATA_W.
    typedef logic [63:0] word_t;

    function automatic logic access_bad(input logic we, input logic [2:0] f3,
                                        input logic [2:0] addr_lo, input logic wide);
        logic legal;
        logic mis;
        legal = 1'b0;
        mis   = 1'b0;
        case (funct3_e'(f3))
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_D:             legal = wide;
            F3_BU, F3_HU:     legal = !we;
            F3_WU:            legal = !we && wide;
            default:          legal = 1'b0;
        endcase
        case (f3[1:0])
            2'd1:    mis = addr_lo[0];
            2'd2:    mis = |addr_lo[1:0];
            2'd3:    mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return !legal || mis;
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] size_log2, input logic [2:0] lane);
        logic [7:0] m;
        case (size_log2)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << lane;
    endfunction

    function automatic word_t replicate(input word_t wdata, input logic [1:0] size_log2);
        case (size_log2)
            2'd0:    return {8{wdata[7:0]}};
            2'd1:    return {4{wdata[15:0]}};
            2'd2:    return {2{wdata[31:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic word_t extract(input word_t word, input logic [2:0] lane, input logic [2:0] f3);
        word_t sh;
        sh = word >> {lane, 3'b000};
        case (funct3_e'(f3))
            F3_B:    return {{56{sh[7]}}, sh[7:0]};
            F3_H:    return {{48{sh[15]}}, sh[15:0]};
            F3_W:    return {{32{sh[31]}}, sh[31:0]};
            F3_BU:   return {56'b0, sh[7:0]};
            F3_HU:   return {48'b0, sh[15:0]};
            F3_WU:   return {32'b0, sh[31:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/be_ram.sv
// Word-wide synchronous RAM with per-byte write enables and a registered
// read port that only updates when a read is requested.
module be_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic [DATA_W/8-1:0]      i_be,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: no reset here -- a memory array cannot be cleared in one edge, so
    // neither the array nor its read register takes the reset.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
        for (int b = 0; b < DATA_W/8; b++) begin
            if (i_we && i_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lsu_datamem.sv
// Single-outstanding load/store unit in front of a byte-enabled data RAM,
// with a fixed request-to-response latency of LAT cycles.
module lsu_datamem
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int DEPTH  = (2 ** ADDR_W) / NB;

    state_e            r_state;
    state_e            w_next;
    logic [1:0]        r_cnt;
    logic              r_we;
    logic              r_err;
    logic [2:0]        r_f3;
    logic [2:0]        r_lane;

    logic              w_accept;
    logic              w_bad;
    logic [2:0]        w_lane;
    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_wdata_rep;
    logic              w_ram_we;
    logic              w_ram_re;
    logic [DATA_W-1:0] w_ram_rdata;

    assign w_accept    = req_valid && (r_state == ST_IDLE);
    assign w_lane      = 3'(req_addr[LANE_W-1:0]);
    assign w_bad       = access_bad(req_we, req_funct3, req_addr[2:0], DATA_W == 64);
    assign w_be        = NB'(lane_mask(req_funct3[1:0], w_lane));
    assign w_wdata_rep = DATA_W'(replicate(word_t'(req_wdata), req_funct3[1:0]));
    // Both the store commit and the load read happen on the accept edge.
    assign w_ram_we    = w_accept && req_we && !w_bad;
    assign w_ram_re    = w_accept && !req_we && !w_bad;

    be_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_be    (w_be),
        .i_addr  (req_addr[ADDR_W-1:LANE_W]),
        .i_wdata (w_wdata_rep),
        .o_rdata (w_ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_next = (LAT == 1) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (r_cnt <= 2'd1) w_next = ST_RESP;
            ST_RESP: if (rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_we   <= 1'b0;
            r_err  <= 1'b0;
            r_f3   <= '0;
            r_lane <= '0;
        end else if (w_accept) begin
            r_cnt  <= 2'(LAT - 1);
            r_we   <= req_we;
            r_err  <= w_bad;
            r_f3   <= req_funct3;
            r_lane <= w_lane;
        end else if (r_state == ST_WAIT && r_cnt != 2'd0) begin
            r_cnt  <= r_cnt - 2'd1;
        end
    end

    // The RAM read register only moves on an accepted load, so data is stable in RESP.
    always_comb begin
        req_ready = (r_state == ST_IDLE);
        rsp_valid = (r_state == ST_RESP);
        rsp_err   = (r_state == ST_RESP) && r_err;
        rsp_rdata = '0;
        if (r_state == ST_RESP && !r_err && !r_we) begin
            rsp_rdata = DATA_W'(extract(word_t'(w_ram_rdata), r_lane, r_f3));
        end
    end

endmodule

// File: tb/tb_lsu_datamem.sv
// Self-checking bench: three lsu_datamem instances (32b/LAT1, 32b/LAT3,
// 64b/LAT2) checked against a byte-array model of the memory.
module tb_lsu_datamem;

    localparam int DW   [3] = '{32, 32, 64};
    localparam int LATV [3] = '{1, 3, 2};

    logic        clk;
    logic        rst;
    logic        req_valid [3];
    logic        req_we    [3];
    logic [2:0]  req_f3    [3];
    logic [8:0]  req_addr  [3];
    logic [63:0] req_wdata [3];
    logic        rsp_ready [3];
    logic        req_ready_o [3];
    logic        rsp_valid_o [3];
    logic        rsp_err_o   [3];
    logic [63:0] rsp_rdata_o [3];
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic [63:0] rd_c;

    assign rsp_rdata_o[0] = {32'b0, rd_a};
    assign rsp_rdata_o[1] = {32'b0, rd_b};
    assign rsp_rdata_o[2] = rd_c;

    lsu_datamem #(.ADDR_W(9), .DATA_W(32), .LAT(1)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready_o[0]),
        .req_we(req_we[0]), .req_funct3(req_f3[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0][31:0]), .rsp_valid(rsp_valid_o[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rd_a), .rsp_err(rsp_err_o[0]));

    lsu_datamem #(.ADDR_W(9), .DATA_W(32), .LAT(3)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready_o[1]),
        .req_we(req_we[1]), .req_funct3(req_f3[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1][31:0]), .rsp_valid(rsp_valid_o[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rd_b), .rsp_err(rsp_err_o[1]));

    lsu_datamem #(.ADDR_W(9), .DATA_W(64), .LAT(2)) u_dut_c (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready_o[2]),
        .req_we(req_we[2]), .req_funct3(req_f3[2]), .req_addr(req_addr[2]),
        .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid_o[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rd_c), .rsp_err(rsp_err_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_fail;
    logic [7:0]  mmem [3][512];
    int          act;
    logic        busy;
    logic [63:0] exp_rdata;
    logic        exp_err;
    logic [63:0] last_rdata;
    logic        last_err;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Access size in bytes, 0 when the funct3 is not supported for this direction/width.
    function automatic int acc_size(input int d, input bit we, input logic [2:0] f3);
        case (f3)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 4;
            3'd3:    return (DW[d] == 64) ? 8 : 0;
            3'd4:    return we ? 0 : 1;
            3'd5:    return we ? 0 : 2;
            3'd6:    return (!we && DW[d] == 64) ? 4 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_err(input int d, input bit we, input logic [2:0] f3, input int addr);
        int sz;
        sz = acc_size(d, we, f3);
        return (sz == 0) || (addr % sz != 0);
    endfunction

    function automatic logic [63:0] model_load(input int d, input logic [2:0] f3, input int addr);
        int          sz;
        logic [63:0] v;
        sz = acc_size(d, 1'b0, f3);
        v  = '0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mmem[d][addr + i];
        if (!f3[2] && sz < 8 && v[8*sz-1]) begin
            for (int i = 8*sz; i < 64; i++) v[i] = 1'b1;
        end
        if (DW[d] == 32) v[63:32] = '0;
        return v;
    endfunction

    always @(negedge clk) begin
        if (busy) begin
            check("busy_req_ready", 64'(req_ready_o[act]), 64'd0);
            if (rsp_valid_o[act]) begin
                check("rsp_rdata", rsp_rdata_o[act], exp_rdata);
                check("rsp_err", 64'(rsp_err_o[act]), 64'(exp_err));
            end
        end
    end

    task automatic do_req(input int d, input bit we, input logic [2:0] f3, input int addr,
                          input logic [63:0] wd, input int hold, input bit abort);
        int n;
        bit ok;
        bit e;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_f3[d]    = f3;
        req_addr[d]  = 9'(addr);
        req_wdata[d] = wd;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready_o[d];
        end
        if (!ok) check("accept_wait", 64'(req_ready_o[d]), 64'd1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        e = model_err(d, we, f3, addr);
        act       = d;
        exp_err   = e;
        exp_rdata = (e || we) ? 64'd0 : model_load(d, f3, addr);
        if (we && !e) begin
            for (int i = 0; i < acc_size(d, we, f3); i++) mmem[d][addr + i] = wd[8*i +: 8];
        end
        if (abort) return;
        busy = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 12) begin
            @(negedge clk);
            n++;
            ok = rsp_valid_o[d];
        end
        check("latency", 64'(n), 64'(LATV[d]));
        last_rdata = rsp_rdata_o[d];
        last_err   = rsp_err_o[d];
        repeat (hold) @(negedge clk);
        @(posedge clk);
        #1 rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[d] = 1'b0;
        busy = 1'b0;
        @(negedge clk);
        check("release_valid", 64'(rsp_valid_o[d]), 64'd0);
        check("release_ready", 64'(req_ready_o[d]), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [63:0] rdata, input logic err);
        check(name, last_rdata, rdata);
        check({name, "_err"}, 64'(last_err), 64'(err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        busy   = 1'b0;
        act    = 0;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_f3[d]    = '0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            rsp_ready[d] = 1'b0;
            for (int a = 0; a < 512; a++) mmem[d][a] = 8'h00;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_req_ready", 64'(req_ready_o[d]), 64'd1);
            check("rst_rsp_valid", 64'(rsp_valid_o[d]), 64'd0);
            check("rst_rsp_rdata", rsp_rdata_o[d], 64'd0);
            check("rst_rsp_err", 64'(rsp_err_o[d]), 64'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 32-bit, LAT=1
        do_req(0, 1, 3'd2, 'h10, 64'hDEADBEEF, 0, 0);
        lit("sw_resp", 64'd0, 1'b0);
        do_req(0, 0, 3'd0, 'h13, 64'd0, 0, 0);
        lit("lb_13", 64'hFFFFFFDE, 1'b0);
        do_req(0, 0, 3'd5, 'h12, 64'd0, 0, 0);
        lit("lhu_12", 64'h0000DEAD, 1'b0);
        do_req(0, 0, 3'd1, 'h12, 64'd0, 0, 0);
        lit("lh_12", 64'hFFFFDEAD, 1'b0);
        do_req(0, 1, 3'd2, 'h20, 64'h44332211, 0, 0);
        do_req(0, 1, 3'd0, 'h21, 64'h00000080, 0, 0);
        do_req(0, 0, 3'd4, 'h21, 64'd0, 0, 0);
        lit("lbu_21", 64'h00000080, 1'b0);
        do_req(0, 0, 3'd2, 'h20, 64'd0, 0, 0);
        lit("lw_20", 64'h44338011, 1'b0);
        do_req(0, 1, 3'd1, 'h22, 64'h0000BEEF, 0, 0);
        do_req(0, 0, 3'd2, 'h20, 64'd0, 0, 0);
        lit("lw_20_sh", 64'hBEEF8011, 1'b0);
        do_req(0, 0, 3'd1, 'h05, 64'd0, 0, 0);
        lit("lh_mis", 64'd0, 1'b1);
        do_req(0, 1, 3'd2, 'h04, 64'hCAFEF00D, 0, 0);
        do_req(0, 1, 3'd2, 'h06, 64'h12345678, 0, 0);
        lit("sw_mis", 64'd0, 1'b1);
        do_req(0, 0, 3'd2, 'h04, 64'd0, 0, 0);
        lit("lw_04", 64'hCAFEF00D, 1'b0);
        do_req(0, 0, 3'd3, 'h08, 64'd0, 0, 0);
        lit("ld_on_32", 64'd0, 1'b1);
        do_req(0, 1, 3'd4, 'h08, 64'h55, 0, 0);
        lit("sbu_bad", 64'd0, 1'b1);
        do_req(0, 0, 3'd7, 'h08, 64'd0, 0, 0);
        lit("f3_7", 64'd0, 1'b1);

        // 32-bit, LAT=3, slow consumer and reset mid-flight
        do_req(1, 1, 3'd2, 'h40, 64'h01234567, 2, 0);
        do_req(1, 0, 3'd2, 'h40, 64'd0, 5, 0);
        lit("lw_40_slow", 64'h01234567, 1'b0);
        do_req(1, 1, 3'd2, 'h30, 64'h11223344, 0, 1);
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(rsp_valid_o[1]), 64'd0);
        check("midrst_ready", 64'(req_ready_o[1]), 64'd1);
        check("midrst_rdata", rsp_rdata_o[1], 64'd0);
        check("midrst_err", 64'(rsp_err_o[1]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_req(1, 0, 3'd2, 'h30, 64'd0, 1, 0);
        lit("lw_30_after_rst", 64'h11223344, 1'b0);

        // 64-bit, LAT=2
        do_req(2, 1, 3'd3, 'h08, 64'h8000000012345678, 0, 0);
        do_req(2, 0, 3'd6, 'h0C, 64'd0, 0, 0);
        lit("lwu_0c", 64'h0000000080000000, 1'b0);
        do_req(2, 0, 3'd3, 'h08, 64'd0, 1, 0);
        lit("ld_08", 64'h8000000012345678, 1'b0);
        do_req(2, 0, 3'd2, 'h0C, 64'd0, 0, 0);
        lit("lw_0c", 64'hFFFFFFFF80000000, 1'b0);
        do_req(2, 0, 3'd0, 'h0B, 64'd0, 0, 0);
        lit("lb_0b", 64'h0000000000000012, 1'b0);
        do_req(2, 1, 3'd0, 'h0F, 64'hAA, 0, 0);
        do_req(2, 0, 3'd3, 'h08, 64'd0, 0, 0);
        lit("ld_08_sb", 64'hAA00000012345678, 1'b0);
        do_req(2, 0, 3'd3, 'h0C, 64'd0, 0, 0);
        lit("ld_mis", 64'd0, 1'b1);
        do_req(2, 0, 3'd1, 'h0F, 64'd0, 0, 0);
        lit("lh_mis64", 64'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_datamem.md
LSU_DATAMEM -- requirements
Module: lsu_datamem

Interface
REQ-001 Parameter ADDR_W, default 9, byte-address width; memory holds 2**ADDR_W bytes.
REQ-002 Parameter DATA_W, default 32, legal values 32 or 64; word width in bits.
REQ-003 Parameter LAT, default 1, legal 1..4; cycles from request accept to response valid.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_funct3  in  3  RISC-V funct3 (size/sign).
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  DATA_W  store data, LSB-aligned.
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  consumer takes response.
REQ-014 rsp_rdata  out  DATA_W  load result, extended to DATA_W.
REQ-015 rsp_err  out  1  misaligned or unsupported access.

Function
REQ-016 FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-017 IDLE: on req_valid&&req_ready, capture request, load counter with LAT-1, go WAIT (LAT>1) or RESP (LAT=1).
REQ-018 WAIT: decrement counter each cycle; at zero go RESP.
REQ-019 RESP: rsp_valid=1, rsp_rdata/rsp_err stable; on rsp_ready go IDLE; otherwise hold indefinitely.
REQ-020 rsp_valid rises exactly LAT cycles after the accept edge.
REQ-021 Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; DATA_W=64 adds 011 LD, 110 LWU.
REQ-022 Stores: 000 SB, 001 SH, 010 SW; DATA_W=64 adds 011 SD.
REQ-023 Byte lane = addr mod (DATA_W/8); store data replicated to lane, only addressed bytes' write enables set.
REQ-024 Signed loads sign-extend from top bit of selected field; unsigned loads zero-extend.
REQ-025 Halfword needs addr[0]=0, word addr[1:0]=0, doubleword addr[2:0]=0; otherwise misaligned.
REQ-026 Misaligned or unsupported funct3: no memory write, rsp_err=1, rsp_rdata=0, normal latency.
REQ-027 Store commits on the accept edge; store response has rsp_rdata=0, rsp_err=0.
REQ-028 Load reads memory on the accept edge; a just-completed earlier store is visible (no hazard, one request in flight).
REQ-029 Requests arriving while not IDLE are ignored (req_ready=0); requester must hold.

Reset
REQ-030 rst forces IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
REQ-031 Reset mid-WAIT/RESP drops the response; a store already committed stays written.
REQ-032 Memory array contents not reset.

Structure
REQ-033 Package lsu_pkg holds funct3 enum, FSM state enum, and lane-select/extend functions.
REQ-034 One sub-module be_ram: word-wide synchronous RAM with per-byte write enables, DEPTH=2**ADDR_W/(DATA_W/8).

Verification
REQ-035 DATA_W=32, LAT=1: SW 0xDEADBEEF @0x10, LB @0x13 -> rsp_rdata=0xFFFFFFDE, 1 cycle after accept.
REQ-036 SB 0x80 @0x21, LBU @0x21 -> 0x00000080; LW @0x20 shows only byte 1 changed.
REQ-037 LH @0x05 -> rsp_err=1, rsp_rdata=0; SW @0x06 -> err=1, LW @0x04 unchanged.
REQ-038 LAT=3, rsp_ready low 5 cycles -> rsp_valid rises 3 cycles after accept, data held stable, req_ready=0 throughout.
REQ-039 DATA_W=64: SD 0x8000000012345678 @0x8, LWU @0xC -> 0x0000000080000000; LD @0x8 returns full value; funct3 011 with DATA_W=32 -> err.
REQ-040 Assert rst during WAIT after SW 0x11223344 @0x30 -> rsp_valid=0 immediately, later LW @0x30 -> 0x11223344.
